// File: rtl/sal_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// sal_cmd_arbiter_if
//   Request/grant bundle between the per-bank scheduler controllers and the
//   command arbiter. It also carries the registered DRAM command bus that the
//   arbiter drives towards the DFI stage.
//
//   Timing configuration (static while traffic is present):
//     t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1 : minimum spacing minus one
//   Per-bank requests / grants (bit i = bank i):
//     act/rd/wr/pre/ref_req_arr, act/rd/wr/pre/ref_gnt_arr
//   Per-bank payload (bank i occupies slice i):
//     ra_arr, ca_arr, id_arr, len_arr
//   Command bus:
//     cmd_valid, cmd_type (0 NOP,1 ACT,2 RD,3 WR,4 PRE,5 REF),
//     cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len
//
//   Modports: master = bank-controller side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface sal_cmd_arbiter_if #(
  parameter int NUM_BANKS = 4,
  parameter int T_RRD_W   = 4,
  parameter int T_CCD_W   = 4,
  parameter int T_WTR_W   = 4,
  parameter int T_RTW_W   = 4,
  parameter int BA_W      = 3,
  parameter int RA_W      = 14,
  parameter int CA_W      = 10,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 8
);

  logic [T_RRD_W-1:0]         t_rrd_m1;
  logic [T_CCD_W-1:0]         t_ccd_m1;
  logic [T_WTR_W-1:0]         t_wtr_m1;
  logic [T_RTW_W-1:0]         t_rtw_m1;

  logic [NUM_BANKS-1:0]       act_req_arr;
  logic [NUM_BANKS-1:0]       rd_req_arr;
  logic [NUM_BANKS-1:0]       wr_req_arr;
  logic [NUM_BANKS-1:0]       pre_req_arr;
  logic [NUM_BANKS-1:0]       ref_req_arr;

  logic [NUM_BANKS*RA_W-1:0]  ra_arr;
  logic [NUM_BANKS*CA_W-1:0]  ca_arr;
  logic [NUM_BANKS*ID_W-1:0]  id_arr;
  logic [NUM_BANKS*LEN_W-1:0] len_arr;

  logic [NUM_BANKS-1:0]       act_gnt_arr;
  logic [NUM_BANKS-1:0]       rd_gnt_arr;
  logic [NUM_BANKS-1:0]       wr_gnt_arr;
  logic [NUM_BANKS-1:0]       pre_gnt_arr;
  logic [NUM_BANKS-1:0]       ref_gnt_arr;

  logic                       cmd_valid;
  logic [2:0]                 cmd_type;
  logic [BA_W-1:0]            cmd_ba;
  logic [RA_W-1:0]            cmd_ra;
  logic [CA_W-1:0]            cmd_ca;
  logic [ID_W-1:0]            cmd_id;
  logic [LEN_W-1:0]           cmd_len;

  modport master (
    output t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1,
    output act_req_arr, rd_req_arr, wr_req_arr, pre_req_arr, ref_req_arr,
    output ra_arr, ca_arr, id_arr, len_arr,
    input  act_gnt_arr, rd_gnt_arr, wr_gnt_arr, pre_gnt_arr, ref_gnt_arr,
    input  cmd_valid, cmd_type, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len
  );

  modport slave (
    input  t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1,
    input  act_req_arr, rd_req_arr, wr_req_arr, pre_req_arr, ref_req_arr,
    input  ra_arr, ca_arr, id_arr, len_arr,
    output act_gnt_arr, rd_gnt_arr, wr_gnt_arr, pre_gnt_arr, ref_gnt_arr,
    output cmd_valid, cmd_type, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len
  );

endinterface

// File: rtl/sal_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// sal_cmd_arbiter
//   Collects ACT/RD/WR/PRE/REF requests from NUM_BANKS bank controllers,
//   enforces the inter-bank spacings tRRD, tCCD, tWTR and tRTW, grants at most
//   one command per cycle with round-robin fairness across banks, and
//   registers the winner onto the single DRAM command bus.
//
//   Ports:
//     i_clk    controller clock
//     i_rst_n  asynchronous active-low reset
//     bus      sal_cmd_arbiter_if.slave (timing config, requests, payload,
//              grants, command bus)
// ---------------------------------------------------------------------------
module sal_cmd_arbiter #(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_PTR_W = $clog2(NUM_BANKS),
  parameter int T_RRD_W    = 4,
  parameter int T_CCD_W    = 4,
  parameter int T_WTR_W    = 4,
  parameter int T_RTW_W    = 4,
  parameter int BA_W       = 3,
  parameter int RA_W       = 14,
  parameter int CA_W       = 10,
  parameter int ID_W       = 4,
  parameter int LEN_W      = 8
) (
  input logic            i_clk,
  input logic            i_rst_n,
  sal_cmd_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_type_e;

  logic [BANK_PTR_W-1:0] r_rr_ptr;
  logic [T_RRD_W-1:0]    r_rrd_cnt;
  logic [T_CCD_W-1:0]    r_ccd_cnt;
  logic [T_WTR_W-1:0]    r_wtr_cnt;
  logic [T_RTW_W-1:0]    r_rtw_cnt;

  logic                  r_cmd_valid;
  cmd_type_e             r_cmd_type;
  logic [BA_W-1:0]       r_cmd_ba;
  logic [RA_W-1:0]       r_cmd_ra;
  logic [CA_W-1:0]       r_cmd_ca;
  logic [ID_W-1:0]       r_cmd_id;
  logic [LEN_W-1:0]      r_cmd_len;

  logic                  w_act_ok;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [NUM_BANKS-1:0]  w_cand;
  logic                  w_win_found;
  logic [BANK_PTR_W-1:0] w_win_bank;
  cmd_type_e             w_win_type;

  // Class-wide eligibility: counters at zero mean the spacing has elapsed.
  assign w_act_ok = (r_rrd_cnt == '0);
  assign w_rd_ok  = (r_ccd_cnt == '0) && (r_wtr_cnt == '0);
  assign w_wr_ok  = (r_ccd_cnt == '0) && (r_rtw_cnt == '0);

  // A bank competes only if at least one of its requests may issue now, so a
  // timing-blocked bank never holds up the banks behind it.
  assign w_cand = bus.ref_req_arr
                | bus.pre_req_arr
                | (bus.act_req_arr & {NUM_BANKS{w_act_ok}})
                | (bus.rd_req_arr  & {NUM_BANKS{w_rd_ok}})
                | (bus.wr_req_arr  & {NUM_BANKS{w_wr_ok}});

  // Round-robin scan from r_rr_ptr; the pointer width makes the index wrap.
  always_comb begin
    logic [BANK_PTR_W-1:0] v_idx;
    w_win_found = 1'b0;
    w_win_bank  = r_rr_ptr;
    v_idx       = r_rr_ptr;
    for (int k = 0; k < NUM_BANKS; k++) begin
      v_idx = r_rr_ptr + BANK_PTR_W'(k);
      if (!w_win_found && w_cand[v_idx]) begin
        w_win_found = 1'b1;
        w_win_bank  = v_idx;
      end
    end
  end

  // Within the winning bank: ref > pre > act > rd > wr, eligible types only.
  always_comb begin
    w_win_type = CMD_NOP;
    if (w_win_found) begin
      if (bus.ref_req_arr[w_win_bank])
        w_win_type = CMD_REF;
      else if (bus.pre_req_arr[w_win_bank])
        w_win_type = CMD_PRE;
      else if (bus.act_req_arr[w_win_bank] && w_act_ok)
        w_win_type = CMD_ACT;
      else if (bus.rd_req_arr[w_win_bank] && w_rd_ok)
        w_win_type = CMD_RD;
      else
        w_win_type = CMD_WR;
    end
  end

  always_comb begin
    bus.act_gnt_arr = '0;
    bus.rd_gnt_arr  = '0;
    bus.wr_gnt_arr  = '0;
    bus.pre_gnt_arr = '0;
    bus.ref_gnt_arr = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (w_win_found && (w_win_bank == BANK_PTR_W'(i))) begin
        bus.act_gnt_arr[i] = (w_win_type == CMD_ACT);
        bus.rd_gnt_arr[i]  = (w_win_type == CMD_RD);
        bus.wr_gnt_arr[i]  = (w_win_type == CMD_WR);
        bus.pre_gnt_arr[i] = (w_win_type == CMD_PRE);
        bus.ref_gnt_arr[i] = (w_win_type == CMD_REF);
      end
    end
  end

  // Pointer moves just past the winner so it becomes lowest priority next.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_win_found) begin
      r_rr_ptr <= w_win_bank + BANK_PTR_W'(1);
    end
  end

  // Spacing counters: load on the granting edge, otherwise count down to 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rrd_cnt <= '0;
      r_ccd_cnt <= '0;
      r_wtr_cnt <= '0;
      r_rtw_cnt <= '0;
    end else begin
      if (w_win_type == CMD_ACT)
        r_rrd_cnt <= bus.t_rrd_m1;
      else if (r_rrd_cnt != '0)
        r_rrd_cnt <= r_rrd_cnt - T_RRD_W'(1);

      if ((w_win_type == CMD_RD) || (w_win_type == CMD_WR))
        r_ccd_cnt <= bus.t_ccd_m1;
      else if (r_ccd_cnt != '0)
        r_ccd_cnt <= r_ccd_cnt - T_CCD_W'(1);

      if (w_win_type == CMD_WR)
        r_wtr_cnt <= bus.t_wtr_m1;
      else if (r_wtr_cnt != '0)
        r_wtr_cnt <= r_wtr_cnt - T_WTR_W'(1);

      if (w_win_type == CMD_RD)
        r_rtw_cnt <= bus.t_rtw_m1;
      else if (r_rtw_cnt != '0)
        r_rtw_cnt <= r_rtw_cnt - T_RTW_W'(1);
    end
  end

  // Command register: address fields hold their last value on idle cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= CMD_NOP;
      r_cmd_ba    <= '0;
      r_cmd_ra    <= '0;
      r_cmd_ca    <= '0;
      r_cmd_id    <= '0;
      r_cmd_len   <= '0;
    end else begin
      r_cmd_valid <= w_win_found;
      r_cmd_type  <= w_win_type;
      if (w_win_found) begin
        r_cmd_ba  <= BA_W'(w_win_bank);
        r_cmd_ra  <= bus.ra_arr[w_win_bank*RA_W +: RA_W];
        r_cmd_ca  <= bus.ca_arr[w_win_bank*CA_W +: CA_W];
        r_cmd_id  <= bus.id_arr[w_win_bank*ID_W +: ID_W];
        r_cmd_len <= bus.len_arr[w_win_bank*LEN_W +: LEN_W];
      end
    end
  end

  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_type  = r_cmd_type;
  assign bus.cmd_ba    = r_cmd_ba;
  assign bus.cmd_ra    = r_cmd_ra;
  assign bus.cmd_ca    = r_cmd_ca;
  assign bus.cmd_id    = r_cmd_id;
  assign bus.cmd_len   = r_cmd_len;

endmodule
